reg_file_gen: RTL and testbench

//  Parametrised accumulator-style register file for the datapath: R0 is the implicit accumulator,
//  and mov-class instructions address any register directly. Operand B can take a zero-extended

---
 rtl/reg_file_gen.sv | 132 +++++++++++++
 tb/tb_reg_file_gen.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/reg_file_gen.sv
// reg_file_gen: accumulator-style register file with a primary (ALU/mov) write
// port, a load write-back port, optional same-cycle read bypass and a
// post-reset clear sweep that holds busy high while every register is zeroed.
module reg_file_gen #(
   parameter int W      = 8,
   parameter int PW     = 4,
   parameter int IMM_W  = 4,
   parameter bit BYPASS = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic             mov_instr,
   input  logic             imm_sel,
   input  logic [IMM_W-1:0] imm_val,
   input  logic [PW-1:0]    addr_a,
   input  logic [PW-1:0]    addr_b,
   input  logic [W-1:0]     dat_in,
   input  logic             ld_en,
   input  logic [PW-1:0]    ld_addr,
   input  logic [W-1:0]     ld_dat,
   output logic [W-1:0]     dat_a_out,
   output logic [W-1:0]     dat_b_out,
   output logic             busy,
   output logic             wr_conflict
);

   localparam int         DEPTH    = 2 ** PW;
   localparam logic [0:0] ST_CLEAR = 1'b0;
   localparam logic [0:0] ST_RUN   = 1'b1;

   logic [0:0]    r_state;
   logic [PW-1:0] r_clr_ptr;
   logic          r_wr_conflict;
   logic [W-1:0]  r_core [DEPTH];

   logic          w_busy;
   logic [PW-1:0] w_tgt_a;
   logic          w_pri_we;
   logic          w_ld_same;
   logic          w_ld_we;
   logic [W-1:0]  w_imm;
   logic [W-1:0]  w_rd_a;
   logic [W-1:0]  w_rd_b;

   // Reset counts as busy so nothing can write while it is held.
   assign w_busy  = reset | (r_state == ST_CLEAR);
   // Non-mov instructions implicitly target the accumulator R0.
   assign w_tgt_a = mov_instr ? addr_a : '0;

   assign w_pri_we  = wr_en & ~w_busy;
   assign w_ld_same = (ld_addr == w_tgt_a);
   // A load aimed at the primary target loses and is dropped outright.
   assign w_ld_we   = ld_en & ~w_busy & ~(w_pri_we & w_ld_same);

   // Zero-extend the immediate; written bitwise so IMM_W == W also works.
   always_comb begin
      w_imm              = '0;
      w_imm[IMM_W-1:0]   = imm_val;
   end

   // Sweep/run control: reset restarts the sweep at R0; the last sweep write moves to RUN.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= ST_CLEAR;
         r_clr_ptr <= '0;
      end else if (r_state == ST_CLEAR) begin
         r_clr_ptr <= r_clr_ptr + 1'b1;
         if (&r_clr_ptr) begin
            r_state <= ST_RUN;
         end
      end
   end

   // Conflict flag covers exactly the cycle after a same-target dual write.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_conflict <= 1'b0;
      end else begin
         r_wr_conflict <= w_pri_we & ld_en & w_ld_same;
      end
   end

   // Register storage: sweep zeroing while clearing, otherwise the two write ports.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (r_state == ST_CLEAR) begin
            r_core[r_clr_ptr] <= '0;
         end else begin
            if (w_ld_we) begin
               r_core[ld_addr] <= ld_dat;
            end
            if (w_pri_we) begin
               r_core[w_tgt_a] <= dat_in;
            end
         end
      end
   end

   // Port A read with optional forwarding; primary data is checked last so it wins.
   always_comb begin
      w_rd_a = r_core[w_tgt_a];
      if (BYPASS) begin
         if (w_ld_we && (ld_addr == w_tgt_a)) begin
            w_rd_a = ld_dat;
         end
         if (w_pri_we) begin
            w_rd_a = dat_in;
         end
      end
   end

   // Port B read with optional forwarding; primary data again has priority.
   always_comb begin
      w_rd_b = r_core[addr_b];
      if (BYPASS) begin
         if (w_ld_we && (ld_addr == addr_b)) begin
            w_rd_b = ld_dat;
         end
         if (w_pri_we && (w_tgt_a == addr_b)) begin
            w_rd_b = dat_in;
         end
      end
   end

   // Outputs are forced to zero while busy; the immediate path bypasses the file entirely.
   assign dat_a_out   = w_busy ? '0 : w_rd_a;
   assign dat_b_out   = w_busy ? '0 : (imm_sel ? w_imm : w_rd_b);
   assign busy        = w_busy;
   assign wr_conflict = r_wr_conflict;

endmodule

// File: tb/tb_reg_file_gen.sv
// tb_reg_file_gen: table-driven vectors through a scoreboard queue, plus
// hand-written sequences for the clear sweep and a mid-sweep reset.
module tb_reg_file_gen;

   logic       clk = 1'b0;
   logic       reset;
   logic       wr_en, mov_instr, imm_sel, ld_en;
   logic [3:0] imm_val, addr_a, addr_b, ld_addr;
   logic [7:0] dat_in, ld_dat;
   logic [7:0] dat_a_out, dat_b_out;
   logic       busy, wr_conflict;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic       wr, mov, ims;
      logic [3:0] imm, aa, ab;
      logic [7:0] din;
      logic       ld;
      logic [3:0] la;
      logic [7:0] ldd;
      logic [7:0] ea, eb;
      logic       ec;
   } vec_t;

   typedef struct {
      logic [7:0] a, b;
      logic       bsy, conf;
      string      name;
   } exp_t;

   exp_t sb_q[$];
   vec_t vecs[18];

   reg_file_gen #(.W(8), .PW(4), .IMM_W(4), .BYPASS(1'b1)) dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .mov_instr(mov_instr),
      .imm_sel(imm_sel), .imm_val(imm_val), .addr_a(addr_a), .addr_b(addr_b),
      .dat_in(dat_in), .ld_en(ld_en), .ld_addr(ld_addr), .ld_dat(ld_dat),
      .dat_a_out(dat_a_out), .dat_b_out(dat_b_out), .busy(busy),
      .wr_conflict(wr_conflict)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic wr, mov, ims, input logic [3:0] imm, aa, ab,
                               input logic [7:0] din, input logic ld, input logic [3:0] la,
                               input logic [7:0] ldd, ea, eb, input logic ec);
      vec_t v;
      v.wr = wr; v.mov = mov; v.ims = ims; v.imm = imm; v.aa = aa; v.ab = ab;
      v.din = din; v.ld = ld; v.la = la; v.ldd = ldd; v.ea = ea; v.eb = eb; v.ec = ec;
      return v;
   endfunction

   task automatic idle_inputs();
      wr_en = 0; mov_instr = 0; imm_sel = 0; ld_en = 0;
      imm_val = 0; addr_a = 0; addr_b = 0; ld_addr = 0; dat_in = 0; ld_dat = 0;
   endtask

   // Drive one RUN-cycle vector and queue what the outputs must show this cycle.
   task automatic drive(input vec_t v, input string nm);
      exp_t e;
      wr_en = v.wr; mov_instr = v.mov; imm_sel = v.ims; imm_val = v.imm;
      addr_a = v.aa; addr_b = v.ab; dat_in = v.din;
      ld_en = v.ld; ld_addr = v.la; ld_dat = v.ldd;
      e.a = v.ea; e.b = v.eb; e.bsy = 1'b0; e.conf = v.ec; e.name = nm;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   // Monitor: compare the queued expectation mid-cycle, away from the clock edge.
   always @(negedge clk) begin
      if (sb_q.size() != 0) begin
         exp_t e;
         e = sb_q.pop_front();
         chk({e.name, ".a"},    32'(dat_a_out),   32'(e.a));
         chk({e.name, ".b"},    32'(dat_b_out),   32'(e.b));
         chk({e.name, ".busy"}, 32'(busy),        32'(e.bsy));
         chk({e.name, ".conf"}, 32'(wr_conflict), 32'(e.conf));
         $display("[TB] txn %s a=%02h b=%02h busy=%0b conf=%0b", e.name,
                  dat_a_out, dat_b_out, busy, wr_conflict);
      end
   end

   // Count busy cycles after reset deasserts; returns at the negedge where busy fell.
   task automatic sweep_count(input string nm, output int cycles);
      cycles = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (!busy) break;
         cycles++;
         chk({nm, ".sweep_a"},    32'(dat_a_out),   32'h0);
         chk({nm, ".sweep_b"},    32'(dat_b_out),   32'h0);
         chk({nm, ".sweep_conf"}, 32'(wr_conflict), 32'h0);
      end
   endtask

   task automatic read_all_zero(input string nm);
      for (int i = 0; i < 16; i++) begin
         drive(mk(0, 1, 0, 4'h0, 4'(i), 4'(i), 8'h00, 0, 4'h0, 8'h00, 8'h00, 8'h00, 0),
               $sformatf("%s_r%0d", nm, i));
      end
   endtask

   initial begin
      int cyc;

      //        wr mov ims imm   aa     ab     din    ld la     ldd    ea     eb     c
      vecs[0]  = mk(1, 1, 0, 4'h0, 4'd5, 4'd5, 8'hA5, 0, 4'd0, 8'h00, 8'hA5, 8'hA5, 0);
      vecs[1]  = mk(0, 1, 0, 4'h0, 4'd5, 4'd0, 8'h00, 0, 4'd0, 8'h00, 8'hA5, 8'h00, 0);
      vecs[2]  = mk(1, 0, 0, 4'h0, 4'd9, 4'd9, 8'h3C, 0, 4'd0, 8'h00, 8'h3C, 8'h00, 0);
      vecs[3]  = mk(0, 0, 0, 4'h0, 4'd9, 4'd0, 8'h00, 0, 4'd0, 8'h00, 8'h3C, 8'h3C, 0);
      vecs[4]  = mk(0, 1, 1, 4'h9, 4'd9, 4'd5, 8'h00, 0, 4'd0, 8'h00, 8'h00, 8'h09, 0);
      vecs[5]  = mk(0, 1, 0, 4'h0, 4'd0, 4'd5, 8'h00, 0, 4'd0, 8'h00, 8'h3C, 8'hA5, 0);
      vecs[6]  = mk(1, 1, 1, 4'hF, 4'd5, 4'd5, 8'h77, 0, 4'd0, 8'h00, 8'h77, 8'h0F, 0);
      vecs[7]  = mk(0, 1, 0, 4'h0, 4'd7, 4'd7, 8'h00, 1, 4'd7, 8'h5A, 8'h5A, 8'h5A, 0);
      vecs[8]  = mk(0, 1, 0, 4'h0, 4'd5, 4'd7, 8'h00, 0, 4'd0, 8'h00, 8'h77, 8'h5A, 0);
      vecs[9]  = mk(1, 1, 0, 4'h0, 4'd3, 4'd3, 8'h11, 1, 4'd3, 8'h22, 8'h11, 8'h11, 0);
      vecs[10] = mk(0, 1, 0, 4'h0, 4'd3, 4'd4, 8'h00, 0, 4'd0, 8'h00, 8'h11, 8'h00, 1);
      vecs[11] = mk(0, 1, 0, 4'h0, 4'd3, 4'd3, 8'h00, 0, 4'd0, 8'h00, 8'h11, 8'h11, 0);
      vecs[12] = mk(1, 1, 0, 4'h0, 4'd3, 4'd4, 8'h11, 1, 4'd4, 8'h22, 8'h11, 8'h22, 0);
      vecs[13] = mk(0, 1, 0, 4'h0, 4'd3, 4'd4, 8'h00, 0, 4'd0, 8'h00, 8'h11, 8'h22, 0);
      vecs[14] = mk(1, 0, 0, 4'h0, 4'd6, 4'd0, 8'h44, 1, 4'd0, 8'h99, 8'h44, 8'h44, 0);
      vecs[15] = mk(0, 0, 0, 4'h0, 4'd6, 4'd6, 8'h00, 0, 4'd0, 8'h00, 8'h44, 8'h00, 1);
      vecs[16] = mk(1, 0, 0, 4'h0, 4'd0, 4'd6, 8'h55, 1, 4'd6, 8'h66, 8'h55, 8'h66, 0);
      vecs[17] = mk(0, 1, 0, 4'h0, 4'd6, 4'd0, 8'h00, 0, 4'd0, 8'h00, 8'h66, 8'h55, 0);

      // Power-up reset held two cycles, then check the reset state.
      idle_inputs();
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("rst.busy", 32'(busy),        32'h1);
      chk("rst.conf", 32'(wr_conflict), 32'h0);
      chk("rst.a",    32'(dat_a_out),   32'h0);
      chk("rst.b",    32'(dat_b_out),   32'h0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      sweep_count("sweep1", cyc);
      chk("sweep1.cycles", 32'(cyc), 32'd16);
      @(posedge clk);
      #1;
      read_all_zero("clr1");

      // Main function vectors.
      for (int i = 0; i < 18; i++) begin
         drive(vecs[i], $sformatf("vec%0d", i));
      end

      // Mid-sweep reset with both write ports hammering R0/R1 throughout.
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      wr_en = 1; mov_instr = 1; addr_a = 4'd0; addr_b = 4'd0; dat_in = 8'hFF;
      ld_en = 1; ld_addr = 4'd1; ld_dat = 8'hEE;
      repeat (7) @(posedge clk);
      #1;
      chk("mid.busy_at_ptr7", 32'(busy), 32'h1);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      sweep_count("sweep2", cyc);
      chk("sweep2.cycles", 32'(cyc), 32'd16);
      idle_inputs();
      @(posedge clk);
      #1;
      read_all_zero("clr2");

      chk("sb.empty", 32'(sb_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
